// File: rtl/avalon_rr_arbiter_if.sv
// Bundle of the N-master request side and the single shared slave side.
// The arbiter uses the slave modport; the master modport is the surrounding system's view.
interface avalon_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    logic [NUM_MASTERS-1:0]          m_read;
    logic [NUM_MASTERS-1:0]          m_write;
    logic [NUM_MASTERS*AW-1:0]       m_address;
    logic [NUM_MASTERS*DW-1:0]       m_writedata;
    logic [NUM_MASTERS*(DW/8)-1:0]   m_byteenable;
    logic [NUM_MASTERS-1:0]          m_waitrequest;
    logic [DW-1:0]                   m_readdata;
    logic [NUM_MASTERS-1:0]          m_readdatavalid;

    logic                            s_read;
    logic                            s_write;
    logic [AW-1:0]                   s_address;
    logic [DW-1:0]                   s_writedata;
    logic [DW/8-1:0]                 s_byteenable;
    logic                            s_waitrequest;
    logic [DW-1:0]                   s_readdata;
    logic                            s_readdatavalid;

    modport slave (
        input  m_read, m_write, m_address, m_writedata, m_byteenable,
        input  s_waitrequest, s_readdata, s_readdatavalid,
        output m_waitrequest, m_readdata, m_readdatavalid,
        output s_read, s_write, s_address, s_writedata, s_byteenable
    );

    modport master (
        output m_read, m_write, m_address, m_writedata, m_byteenable,
        output s_waitrequest, s_readdata, s_readdatavalid,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        input  s_read, s_write, s_address, s_writedata, s_byteenable
    );
endinterface

// File: rtl/avalon_rr_arbiter.sv
// Avalon-MM arbiter: N masters share one slave, one transaction outstanding at a time.
// Define VERIRISCV_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
module avalon_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_rr_arbiter_if.slave   bus
);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] winner;
    logic [NUM_MASTERS-1:0] req;
    logic                   found;

    logic                   sel_read;
    logic                   sel_write;
    logic [AW-1:0]          sel_address;
    logic [DW-1:0]          sel_writedata;
    logic [BW-1:0]          sel_byteenable;

    assign req = bus.m_read | bus.m_write;

`ifdef VERIRISCV_ARB_RR_EN
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner_idx;
    logic [IW-1:0] idx;

    // Search begins just after the previous winner and wraps, so nobody starves.
    always_comb begin
        winner     = '0;
        winner_idx = last_grant;
        found      = 1'b0;
        idx        = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_MASTERS);
            if (!found && req[idx]) begin
                found       = 1'b1;
                winner[idx] = 1'b1;
                winner_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IW'(NUM_MASTERS - 1);
        end else if (state == IDLE && |req) begin
            last_grant <= winner_idx;
        end
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[k]) begin
                found     = 1'b1;
                winner[k] = 1'b1;
            end
        end
    end
`endif

    // AND-OR mux of the granted master; an empty grant yields all zeros.
    always_comb begin
        sel_read       = 1'b0;
        sel_write      = 1'b0;
        sel_address    = '0;
        sel_writedata  = '0;
        sel_byteenable = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel_read       = sel_read  | (bus.m_read[i]  & grant[i]);
            sel_write      = sel_write | (bus.m_write[i] & grant[i]);
            sel_address    = sel_address    | (bus.m_address[i*AW +: AW]    & {AW{grant[i]}});
            sel_writedata  = sel_writedata  | (bus.m_writedata[i*DW +: DW]  & {DW{grant[i]}});
            sel_byteenable = sel_byteenable | (bus.m_byteenable[i*BW +: BW] & {BW{grant[i]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == BUSY) begin
                grant <= winner;
            end else if (next_state == IDLE) begin
                grant <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (|req) next_state = BUSY;
            BUSY: if (!bus.s_waitrequest) next_state = sel_read ? RESP : IDLE;
            RESP: if (bus.s_readdatavalid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Read wins over a simultaneous write from the same master.
    assign bus.s_read          = (state == BUSY) && sel_read;
    assign bus.s_write         = (state == BUSY) && sel_write && !sel_read;
    assign bus.s_address       = sel_address;
    assign bus.s_writedata     = sel_writedata;
    assign bus.s_byteenable    = sel_byteenable;
    assign bus.m_waitrequest   = (state == BUSY) ? (~grant | {NUM_MASTERS{bus.s_waitrequest}})
                                                 : {NUM_MASTERS{1'b1}};
    assign bus.m_readdatavalid = (state == RESP && bus.s_readdatavalid) ? grant : '0;
    assign bus.m_readdata      = bus.s_readdata;
endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Testbench for avalon_rr_arbiter: directed scenarios with literal expectations, then
// randomized masters and slave checked every cycle against a transaction-level model.
module tb_avalon_rr_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    avalon_rr_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

    avalon_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic          rd_v   [N];
    logic          wr_v   [N];
    logic [AW-1:0] addr_v [N];
    logic [DW-1:0] data_v [N];
    logic [BW-1:0] be_v   [N];
    logic          rst_v;
    logic          swait_v;
    logic          srdv_v;
    logic [DW-1:0] srdata_v;

    // Model: who owns the slave (-1 = nobody) and whether the read data is still owed.
    int owner;
    bit awaiting;
    int last;

    logic          exp_sread;
    logic          exp_swrite;
    logic [N-1:0]  exp_wait;
    logic [N-1:0]  exp_rdv;

    int vectors     = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pickWinner();
`ifdef VERIRISCV_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (rd_v[c] || wr_v[c]) return c;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (rd_v[k] || wr_v[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic modelReset();
        owner    = -1;
        awaiting = 1'b0;
        last     = N - 1;
    endtask

    task automatic compareModel();
        bit requesting;
        requesting = (owner >= 0) && !awaiting;
        exp_sread  = 1'b0;
        exp_swrite = 1'b0;
        exp_wait   = '1;
        exp_rdv    = '0;
        if (requesting) begin
            exp_sread       = rd_v[owner];
            exp_swrite      = wr_v[owner] && !rd_v[owner];
            exp_wait[owner] = swait_v;
        end else if (owner >= 0) begin
            exp_rdv[owner] = srdv_v;
        end
        checkOutput("s_read", 64'(bus.s_read), 64'(exp_sread));
        checkOutput("s_write", 64'(bus.s_write), 64'(exp_swrite));
        checkOutput("m_waitrequest", 64'(bus.m_waitrequest), 64'(exp_wait));
        checkOutput("m_readdatavalid", 64'(bus.m_readdatavalid), 64'(exp_rdv));
        checkOutput("m_readdata", 64'(bus.m_readdata), 64'(srdata_v));
        if (requesting) begin
            checkOutput("s_address", 64'(bus.s_address), 64'(addr_v[owner]));
            checkOutput("s_writedata", 64'(bus.s_writedata), 64'(data_v[owner]));
            checkOutput("s_byteenable", 64'(bus.s_byteenable), 64'(be_v[owner]));
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        rst = rst_v;
        for (int i = 0; i < N; i++) begin
            bus.m_read[i]                  = rd_v[i];
            bus.m_write[i]                 = wr_v[i];
            bus.m_address[i*AW +: AW]      = addr_v[i];
            bus.m_writedata[i*DW +: DW]    = data_v[i];
            bus.m_byteenable[i*BW +: BW]   = be_v[i];
        end
        bus.s_waitrequest   = swait_v;
        bus.s_readdatavalid = srdv_v;
        bus.s_readdata      = srdata_v;
        #1;
        if (rst_v) modelReset();
        compareModel();
    endtask

    task automatic advance();
        int w;
        if (!rst_v) begin
            if (owner < 0) begin
                w = pickWinner();
                if (w >= 0) begin
                    owner    = w;
                    last     = w;
                    awaiting = 1'b0;
                end
            end else if (!awaiting) begin
                if (!swait_v) begin
                    if (rd_v[owner]) awaiting = 1'b1;
                    else owner = -1;
                end
            end else if (srdv_v) begin
                owner = -1;
            end
        end
        @(posedge clk);
    endtask

    task automatic clearStim();
        for (int i = 0; i < N; i++) begin
            rd_v[i]   = 1'b0;
            wr_v[i]   = 1'b0;
            addr_v[i] = '0;
            data_v[i] = '0;
            be_v[i]   = '0;
        end
        rst_v    = 1'b0;
        swait_v  = 1'b0;
        srdv_v   = 1'b0;
        srdata_v = '0;
    endtask

    bit active [N];
    bit pend;
    int lat;

    initial begin
        rst = 1'b1;
        modelReset();
        clearStim();

        // Reset state
        rst_v = 1'b1;
        applyStimulus();
        checkOutput("reset s_read", 64'(bus.s_read), 64'h0);
        checkOutput("reset s_write", 64'(bus.s_write), 64'h0);
        checkOutput("reset m_waitrequest", 64'(bus.m_waitrequest), 64'h3);
        checkOutput("reset m_readdatavalid", 64'(bus.m_readdatavalid), 64'h0);
        advance();
        rst_v = 1'b0;

        // Single read from master 0, data three cycles after acceptance
        rd_v[0] = 1'b1; addr_v[0] = 32'h100;
        applyStimulus();
        checkOutput("rd arb cycle s_read", 64'(bus.s_read), 64'h0);
        advance();
        applyStimulus();
        checkOutput("rd s_read", 64'(bus.s_read), 64'h1);
        checkOutput("rd s_address", 64'(bus.s_address), 64'h100);
        advance();
        rd_v[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin srdv_v = 1'b1; srdata_v = 32'hDEADBEEF; end
            applyStimulus();
            checkOutput("rd m_readdatavalid", 64'(bus.m_readdatavalid), (c == 2) ? 64'h1 : 64'h0);
            if (c == 2) checkOutput("rd m_readdata", 64'(bus.m_readdata), 64'hDEADBEEF);
            advance();
        end
        clearStim();
        applyStimulus();
        checkOutput("rd after pulse rdv", 64'(bus.m_readdatavalid), 64'h0);
        advance();

        // Write from master 1 with two stall cycles
        wr_v[1] = 1'b1; addr_v[1] = 32'h200; data_v[1] = 32'h1234; be_v[1] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            swait_v = (c == 1 || c == 2);
            applyStimulus();
            checkOutput("wr m_waitrequest[1]", 64'(bus.m_waitrequest[1]), (c == 3) ? 64'h0 : 64'h1);
            if (c > 0) checkOutput("wr s_writedata", 64'(bus.s_writedata), 64'h1234);
            advance();
        end
        clearStim();
        applyStimulus();
        checkOutput("wr back to idle", 64'({bus.s_write, bus.m_waitrequest}), 64'h3);
        advance();

        // Both masters writing continuously
        wr_v[0] = 1'b1; wr_v[1] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            int g;
            logic [N-1:0] want;
            applyStimulus();
`ifdef VERIRISCV_ARB_RR_EN
            g = (j / 2) % 2;
`else
            g = 0;
`endif
            want = (j % 2 == 1) ? ~(N'(1) << g) : '1;
            checkOutput("contention grant", 64'(bus.m_waitrequest), 64'(want));
            advance();
        end
        clearStim();

        // Master 0 read in flight while master 1 waits
        rd_v[0] = 1'b1; addr_v[0] = 32'h300;
        applyStimulus(); advance();
        applyStimulus(); advance();
        rd_v[0] = 1'b0;
        wr_v[1] = 1'b1; addr_v[1] = 32'h304; data_v[1] = 32'h55AA; be_v[1] = 4'h3;
        for (int c = 0; c < 3; c++) begin
            srdv_v = (c == 2);
            applyStimulus();
            checkOutput("inflight m_waitrequest[1]", 64'(bus.m_waitrequest[1]), 64'h1);
            if (c == 2) checkOutput("inflight rdv", 64'(bus.m_readdatavalid), 64'h1);
            advance();
        end
        srdv_v = 1'b0;
        applyStimulus();
        checkOutput("inflight idle gap", 64'(bus.m_waitrequest), 64'h3);
        advance();
        applyStimulus();
        checkOutput("inflight m1 granted", 64'(bus.m_waitrequest), 64'h1);
        advance();
        clearStim();

        // Reset while awaiting read data, then a late response
        rd_v[0] = 1'b1; addr_v[0] = 32'h400;
        applyStimulus(); advance();
        applyStimulus(); advance();
        rd_v[0] = 1'b0;
        applyStimulus();
        rst_v = 1'b1;
        rst   = 1'b1;
        #1;
        checkOutput("async reset s_read", 64'(bus.s_read), 64'h0);
        checkOutput("async reset m_waitrequest", 64'(bus.m_waitrequest), 64'h3);
        modelReset();
        advance();
        srdv_v = 1'b1; srdata_v = 32'hCAFEF00D;
        applyStimulus();
        checkOutput("late rsp in reset rdv", 64'(bus.m_readdatavalid), 64'h0);
        advance();
        rst_v = 1'b0;
        applyStimulus();
        checkOutput("late rsp after reset rdv", 64'(bus.m_readdatavalid), 64'h0);
        advance();

        // Spurious response in IDLE is ignored
        applyStimulus();
        checkOutput("spurious rdv", 64'(bus.m_readdatavalid), 64'h0);
        advance();
        srdv_v = 1'b0;
        wr_v[0] = 1'b1; addr_v[0] = 32'h500; data_v[0] = 32'h77; be_v[0] = 4'h1;
        applyStimulus();
        checkOutput("spurious still idle", 64'({bus.s_write, bus.m_waitrequest}), 64'h3);
        advance();
        applyStimulus();
        checkOutput("spurious then write", 64'(bus.s_write), 64'h1);
        advance();
        clearStim();

        // Randomized masters and slave
        pend = 1'b0;
        lat  = 0;
        for (int i = 0; i < N; i++) active[i] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!active[i] && $urandom_range(0, 2) == 0) begin
                    active[i] = 1'b1;
                    rd_v[i]   = $urandom_range(0, 1) == 1;
                    wr_v[i]   = !rd_v[i];
                    addr_v[i] = $urandom;
                    data_v[i] = $urandom;
                    be_v[i]   = BW'($urandom);
                end else if (!active[i]) begin
                    rd_v[i] = 1'b0;
                    wr_v[i] = 1'b0;
                end
            end
            swait_v = ($urandom_range(0, 2) == 0);
            if (pend) begin
                if (lat == 0) begin
                    srdv_v   = 1'b1;
                    srdata_v = $urandom;
                    pend     = 1'b0;
                end else begin
                    srdv_v = 1'b0;
                    lat--;
                end
            end else begin
                srdv_v   = ($urandom_range(0, 9) == 0);
                srdata_v = $urandom;
            end
            applyStimulus();
            for (int i = 0; i < N; i++) begin
                if (active[i] && exp_wait[i] == 1'b0) active[i] = 1'b0;
            end
            if (exp_sread && !swait_v) begin
                pend = 1'b1;
                lat  = $urandom_range(0, 3);
            end
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
